// File: rtl/svc_rv_div_mc.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divider that
// captures forwarded operands and stalls EX until the result is ready.
module svc_rv_div_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] fwd_rs1_ex,
  input  logic [XLEN-1:0] fwd_rs2_ex,
  input  logic            flush,
  output logic            is_mc,
  output logic [XLEN-1:0] mc_rs1,
  output logic [XLEN-1:0] mc_rs2,
  output logic            stall_ex,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mc_rs1_q, mc_rs2_q, dvd_q, dvs_q, rem_q, result_q;
  logic            rem_sel_q, negq_q, negr_q;

  logic            capture, sgn_in, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0]   rem_sh, diff;
  logic            qbit;
  logic [XLEN-1:0] rem_nx, quo_nx, fin_q, fin_r, fin;

  // DIV (0) and REM (2) are the signed ops
  assign capture  = (state_q == S_IDLE) & en & ~flush;
  assign sgn_in   = ~op[0];
  assign a_neg    = sgn_in & fwd_rs1_ex[XLEN-1];
  assign b_neg    = sgn_in & fwd_rs2_ex[XLEN-1];
  assign a_mag    = a_neg ? -fwd_rs1_ex : fwd_rs1_ex;
  assign b_mag    = b_neg ? -fwd_rs2_ex : fwd_rs2_ex;
  assign div0     = (fwd_rs2_ex == '0);
  assign ovf      = sgn_in & (fwd_rs1_ex == SMIN) & (fwd_rs2_ex == '1);
  assign special  = div0 | ovf;
  assign spec_res = op[1] ? (div0 ? fwd_rs1_ex : '0) : (div0 ? '1 : SMIN);

  // One restoring step: dvd_q shifts the dividend out and the quotient in
  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign qbit   = ~diff[XLEN];
  assign rem_nx = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx = {dvd_q[XLEN-2:0], qbit};
  assign fin_q  = negq_q ? -quo_nx : quo_nx;
  assign fin_r  = negr_q ? -rem_nx : rem_nx;
  assign fin    = rem_sel_q ? fin_r : fin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (capture) begin
        state_d = special ? S_DONE : S_RUN;
        cnt_d   = CW'(XLEN);
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mc_rs1_q  <= '0;
      mc_rs2_q  <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        mc_rs1_q  <= fwd_rs1_ex;
        mc_rs2_q  <= fwd_rs2_ex;
        dvd_q     <= a_mag;
        dvs_q     <= b_mag;
        rem_q     <= '0;
        rem_sel_q <= op[1];
        negq_q    <= a_neg ^ b_neg;
        negr_q    <= a_neg;
        if (special) result_q <= spec_res;
      end else if ((state_q == S_RUN) && !flush) begin
        rem_q <= rem_nx;
        dvd_q <= quo_nx;
        if (cnt_q == CW'(1)) result_q <= fin;
      end
    end
  end

  assign is_mc        = (state_q != S_IDLE);
  assign mc_rs1       = mc_rs1_q;
  assign mc_rs2       = mc_rs2_q;
  assign result       = result_q;
  // A flushed op must never write back, even from DONE
  assign result_valid = (state_q == S_DONE) & ~flush;
  assign stall_ex     = en & ~result_valid;
endmodule
